// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter: port 0 (fetch, read-only) and port 1 (data, read/write) share
// one mem_system. Optional statistics counters are enabled with the ARB_STATS_EN macro.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p0_rd,
    input  logic [15:0] i_p0_addr,
    output logic        o_p0_done,
    output logic [15:0] o_p0_data_out,
    input  logic        i_p1_rd,
    input  logic        i_p1_wr,
    input  logic [15:0] i_p1_addr,
    input  logic [15:0] i_p1_data_in,
    output logic        o_p1_done,
    output logic [15:0] o_p1_data_out,
    output logic        o_p1_hit,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data_in,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic [15:0] i_mem_data_out,
    input  logic        i_mem_done,
    input  logic        i_mem_stall,
    input  logic        i_mem_hit,
`ifdef ARB_STATS_EN
    output logic [15:0] o_p0_req_cnt,
    output logic [15:0] o_p1_req_cnt,
    output logic [15:0] o_p1_hit_cnt,
`endif
    output logic        o_err
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_e      r_state;
    state_e      w_state_d;
    logic        r_last_grant;
    logic        r_owner;
    logic [7:0]  r_timer;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_data_in;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_p0_done;
    logic        r_p1_done;
    logic [15:0] r_p0_data;
    logic [15:0] r_p1_data;
    logic        r_p1_hit;
    logic        r_err;

    logic        w_p0_req;
    logic        w_p1_req;
    logic        w_p1_illegal;
    logic        w_done_pulse;
    logic        w_accept;
    logic        w_grant;
    logic        w_finish;
    logic        w_abort;
    logic [15:0] w_rdata;

    assign w_p0_req     = i_p0_rd;
    assign w_p1_illegal = i_p1_rd & i_p1_wr;
    assign w_p1_req     = i_p1_rd ^ i_p1_wr;
    // Requesters still hold their request during the done cycle; do not re-accept it.
    assign w_done_pulse = r_p0_done | r_p1_done;
    assign w_rdata      = (w_finish && r_mem_rd) ? i_mem_data_out : 16'h0000;

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_grant   = 1'b0;
        w_finish  = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!i_mem_stall && !w_done_pulse && (w_p0_req || w_p1_req)) begin
                    w_accept  = 1'b1;
                    w_grant   = w_p1_req && (!w_p0_req || !r_last_grant);
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (i_mem_done) begin
                    w_finish = 1'b1;
                end else if (r_timer == TimerLast) begin
                    w_abort = 1'b1;
                end
                if (w_finish || w_abort) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= StIdle;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_timer       <= 8'd0;
            r_mem_addr    <= 16'h0000;
            r_mem_data_in <= 16'h0000;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_p0_done     <= 1'b0;
            r_p1_done     <= 1'b0;
            r_p0_data     <= 16'h0000;
            r_p1_data     <= 16'h0000;
            r_p1_hit      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            if (w_p1_illegal) begin
                r_err <= 1'b1;
            end
            if (r_state == StBusy) begin
                r_timer <= r_timer + 8'd1;
            end
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_timer      <= 8'd0;
                if (w_grant) begin
                    r_mem_addr    <= i_p1_addr;
                    r_mem_data_in <= i_p1_data_in;
                    r_mem_rd      <= i_p1_rd;
                    r_mem_wr      <= i_p1_wr;
                end else begin
                    r_mem_addr    <= i_p0_addr;
                    r_mem_data_in <= 16'h0000;
                    r_mem_rd      <= 1'b1;
                    r_mem_wr      <= 1'b0;
                end
            end
            if (w_finish || w_abort) begin
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                r_timer  <= 8'd0;
                if (w_abort) begin
                    r_err <= 1'b1;
                end
                if (r_owner) begin
                    r_p1_done <= 1'b1;
                    r_p1_data <= w_rdata;
                    r_p1_hit  <= w_finish & i_mem_hit;
                end else begin
                    r_p0_done <= 1'b1;
                    r_p0_data <= w_rdata;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_p0_req_cnt;
    logic [15:0] r_p1_req_cnt;
    logic [15:0] r_p1_hit_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_p0_req_cnt <= 16'h0000;
            r_p1_req_cnt <= 16'h0000;
            r_p1_hit_cnt <= 16'h0000;
        end else if (w_finish || w_abort) begin
            if (r_owner) begin
                r_p1_req_cnt <= r_p1_req_cnt + 16'd1;
                if (w_finish && i_mem_hit) begin
                    r_p1_hit_cnt <= r_p1_hit_cnt + 16'd1;
                end
            end else begin
                r_p0_req_cnt <= r_p0_req_cnt + 16'd1;
            end
        end
    end

    assign o_p0_req_cnt = r_p0_req_cnt;
    assign o_p1_req_cnt = r_p1_req_cnt;
    assign o_p1_hit_cnt = r_p1_hit_cnt;
`endif

    assign o_p0_done     = r_p0_done;
    assign o_p0_data_out = r_p0_data;
    assign o_p1_done     = r_p1_done;
    assign o_p1_data_out = r_p1_data;
    assign o_p1_hit      = r_p1_hit;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data_in = r_mem_data_in;
    assign o_mem_rd      = r_mem_rd;
    assign o_mem_wr      = r_mem_wr;
    assign o_err         = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=8); stimulus is driven and sampled
// on the falling clock edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_rd;
    logic [15:0] p0_addr;
    logic        p0_done;
    logic [15:0] p0_data_out;
    logic        p1_rd;
    logic        p1_wr;
    logic [15:0] p1_addr;
    logic [15:0] p1_data_in;
    logic        p1_done;
    logic [15:0] p1_data_out;
    logic        p1_hit;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_data_out;
    logic        mem_done;
    logic        mem_stall;
    logic        mem_hit;
    logic        err;
`ifdef ARB_STATS_EN
    logic [15:0] p0_req_cnt;
    logic [15:0] p1_req_cnt;
    logic [15:0] p1_hit_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_p0_rd        (p0_rd),
        .i_p0_addr      (p0_addr),
        .o_p0_done      (p0_done),
        .o_p0_data_out  (p0_data_out),
        .i_p1_rd        (p1_rd),
        .i_p1_wr        (p1_wr),
        .i_p1_addr      (p1_addr),
        .i_p1_data_in   (p1_data_in),
        .o_p1_done      (p1_done),
        .o_p1_data_out  (p1_data_out),
        .o_p1_hit       (p1_hit),
        .o_mem_addr     (mem_addr),
        .o_mem_data_in  (mem_data_in),
        .o_mem_rd       (mem_rd),
        .o_mem_wr       (mem_wr),
        .i_mem_data_out (mem_data_out),
        .i_mem_done     (mem_done),
        .i_mem_stall    (mem_stall),
        .i_mem_hit      (mem_hit),
`ifdef ARB_STATS_EN
        .o_p0_req_cnt   (p0_req_cnt),
        .o_p1_req_cnt   (p1_req_cnt),
        .o_p1_hit_cnt   (p1_hit_cnt),
`endif
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        p0_rd = 0; p0_addr = 0; p1_rd = 0; p1_wr = 0; p1_addr = 0; p1_data_in = 0;
        mem_data_out = 0; mem_done = 0; mem_stall = 0; mem_hit = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    // Advance falling edges until a memory access is issued; ok=0 if the bound expires.
    task automatic wait_issue(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd || mem_wr) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called in the first BUSY cycle; returns on the falling edge where the done pulse shows.
    task automatic mem_respond(input logic [15:0] d, input logic h, input int lat);
        repeat (lat - 1) @(negedge clk);
        mem_data_out = d; mem_hit = h; mem_done = 1;
        @(negedge clk);
        mem_done = 0; mem_hit = 0;
    endtask

    task automatic test_reset();
        bit bad = 0;
        clear_inputs();
        rst = 0; p0_rd = 1; p0_addr = 16'h0010;
        repeat (3) begin
            @(negedge clk);
            if ({mem_rd, mem_wr, p0_done, p1_done, p1_hit, err} !== 6'b0 ||
                p0_data_out !== 0 || p1_data_out !== 0 || mem_addr !== 0 || mem_data_in !== 0)
                bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        rst = 1;
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin
            n_errors++;
            $display("FAIL reset_release: mem_rd=%b mem_addr=%h, required 1 0010", mem_rd, mem_addr);
        end
    endtask

    task automatic test_single_read();
        mem_respond(16'h1234, 1'b0, 2);
        n_checks++;
        if (p0_done !== 1'b1 || p0_data_out !== 16'h1234 || p1_done !== 1'b0 || mem_rd !== 1'b0) begin
            n_errors++;
            $display("FAIL p0_read: done=%b data=%h p1_done=%b mem_rd=%b, required 1 1234 0 0",
                     p0_done, p0_data_out, p1_done, mem_rd);
        end
        p0_rd = 0;
        @(negedge clk);
        n_checks++;
        if (p0_done !== 1'b0 || p0_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL p0_hold: done=%b data=%h, required 0 1234", p0_done, p0_data_out);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        p0_rd = 1; p0_addr = 16'h0020;
        p1_wr = 1; p1_addr = 16'h0040; p1_data_in = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            wait_issue(ok);
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL rr_issue%0d: no access issued, required one", k);
            end else if ((k % 2) == 0) begin
                n_checks++;
                if (mem_rd !== 1 || mem_wr !== 0 || mem_addr !== 16'h0020) begin
                    n_errors++;
                    $display("FAIL rr_p0_req%0d: rd=%b wr=%b addr=%h, required 1 0 0020",
                             k, mem_rd, mem_wr, mem_addr);
                end
                mem_respond(16'h5500 + 16'(k), 1'b0, 2);
                n_checks++;
                if (p0_done !== 1 || p1_done !== 0 || p0_data_out !== 16'h5500 + 16'(k)) begin
                    n_errors++;
                    $display("FAIL rr_p0_done%0d: p0=%b p1=%b data=%h, required 1 0 %h",
                             k, p0_done, p1_done, p0_data_out, 16'h5500 + 16'(k));
                end
            end else begin
                n_checks++;
                if (mem_rd !== 0 || mem_wr !== 1 || mem_addr !== 16'h0040 || mem_data_in !== 16'hBEEF) begin
                    n_errors++;
                    $display("FAIL rr_p1_req%0d: rd=%b wr=%b addr=%h din=%h, required 0 1 0040 beef",
                             k, mem_rd, mem_wr, mem_addr, mem_data_in);
                end
                mem_respond(16'h9999, 1'b1, 1);
                n_checks++;
                if (p1_done !== 1 || p0_done !== 0 || p1_data_out !== 16'h0000 || p1_hit !== 1) begin
                    n_errors++;
                    $display("FAIL rr_p1_done%0d: p1=%b p0=%b data=%h hit=%b, required 1 0 0000 1",
                             k, p1_done, p0_done, p1_data_out, p1_hit);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_p1_read();
        bit ok;
        do_reset();
        p1_rd = 1; p1_addr = 16'h0070;
        wait_issue(ok);
        p1_addr = 16'hFFFF;
        @(negedge clk);
        n_checks++;
        if (!ok || mem_rd !== 1 || mem_wr !== 0 || mem_addr !== 16'h0070) begin
            n_errors++;
            $display("FAIL p1_read_issue: ok=%b rd=%b wr=%b addr=%h, required 1 1 0 0070",
                     ok, mem_rd, mem_wr, mem_addr);
        end
        mem_respond(16'hCAFE, 1'b1, 2);
        n_checks++;
        if (p1_done !== 1 || p1_data_out !== 16'hCAFE || p1_hit !== 1 || p0_done !== 0) begin
            n_errors++;
            $display("FAIL p1_read_done: done=%b data=%h hit=%b p0=%b, required 1 cafe 1 0",
                     p1_done, p1_data_out, p1_hit, p0_done);
        end
        clear_inputs();
    endtask

    task automatic test_illegal();
        bit ok;
        bit issued = 0;
        do_reset();
        p1_rd = 1; p1_wr = 1; p1_addr = 16'h0008;
        p0_rd = 1; p0_addr = 16'h0030;
        wait_issue(ok);
        n_checks++;
        if (!ok || mem_rd !== 1 || mem_wr !== 0 || mem_addr !== 16'h0030 || err !== 1) begin
            n_errors++;
            $display("FAIL illegal_p0_issue: ok=%b rd=%b wr=%b addr=%h err=%b, required 1 1 0 0030 1",
                     ok, mem_rd, mem_wr, mem_addr, err);
        end
        mem_respond(16'h0A0A, 1'b0, 2);
        n_checks++;
        if (p0_done !== 1 || p0_data_out !== 16'h0A0A || p1_done !== 0) begin
            n_errors++;
            $display("FAIL illegal_p0_done: p0=%b data=%h p1=%b, required 1 0a0a 0",
                     p0_done, p0_data_out, p1_done);
        end
        p0_rd = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_rd || mem_wr || p1_done) issued = 1;
        end
        n_checks++;
        if (issued) begin
            n_errors++;
            $display("FAIL illegal_blocked: illegal p1 request reached memory, required never");
        end
        p1_rd = 0; p1_wr = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1) begin
            n_errors++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        bit rd_early = 0;
        do_reset();
        p0_rd = 1; p0_addr = 16'h0050;
        wait_issue(ok);
        mem_respond(16'h7777, 1'b0, 1);
        n_checks++;
        if (p0_done !== 1 || p0_data_out !== 16'h7777 || err !== 0) begin
            n_errors++;
            $display("FAIL pre_timeout_read: done=%b data=%h err=%b, required 1 7777 0",
                     p0_done, p0_data_out, err);
        end
        wait_issue(ok);
        while (!p0_done && n < 20) begin
            if (n < 8 && !mem_rd) rd_early = 1;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!ok || n !== 8 || rd_early) begin
            n_errors++;
            $display("FAIL timeout_latency: ok=%b cycles=%0d rd_dropped_early=%b, required 1 8 0",
                     ok, n, rd_early);
        end
        n_checks++;
        if (p0_done !== 1 || p0_data_out !== 16'h0000 || err !== 1 || mem_rd !== 0) begin
            n_errors++;
            $display("FAIL timeout_abort: done=%b data=%h err=%b mem_rd=%b, required 1 0000 1 0",
                     p0_done, p0_data_out, err, mem_rd);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_and_idle_done();
        bit ok;
        bit spurious = 0;
        do_reset();
        p1_rd = 1; p1_addr = 16'h0060;
        wait_issue(ok);
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (!ok || mem_rd !== 0 || p1_done !== 0 || p0_done !== 0) begin
            n_errors++;
            $display("FAIL reset_mid: ok=%b mem_rd=%b p1_done=%b p0_done=%b, required 1 0 0 0",
                     ok, mem_rd, p1_done, p0_done);
        end
        p1_rd = 0;
        rst = 1;
        mem_done = 1; mem_data_out = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            if (p0_done || p1_done || mem_rd || mem_wr) spurious = 1;
        end
        mem_done = 0;
        n_checks++;
        if (spurious) begin
            n_errors++;
            $display("FAIL idle_done: done pulse or access from mem_done in IDLE, required none");
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            p1_rd = 1; p1_addr = 16'(k);
            wait_issue(ok);
            mem_respond(16'(k), (k < 3) ? 1'b1 : 1'b0, 2);
            p1_rd = 0;
            @(negedge clk);
        end
        n_checks++;
        if (p1_req_cnt !== 16'd5 || p1_hit_cnt !== 16'd3 || p0_req_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL stats: p1_req=%0d p1_hit=%0d p0_req=%0d, required 5 3 0",
                     p1_req_cnt, p1_hit_cnt, p0_req_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_p1_read();
        test_illegal();
        test_timeout();
        test_reset_mid_and_idle_done();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
